// File: rtl/centroid_divider_pkg.sv
// Shared widths, derived divider step count and state encoding for the
// centroid divider and its sequential restoring divider.
package centroid_divider_pkg;

  localparam int SUM_S_W   = 20;
  localparam int SUM_XY_W  = 28;
  localparam int COORD_W   = 10;
  localparam int FRAC_W    = 4;
  localparam int DIV_STEPS = SUM_XY_W + FRAC_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_X,
    DIV_X,
    LOAD_Y,
    DIV_Y,
    OUT
  } state_t;

endpackage

// File: rtl/seq_restoring_div.sv
// Radix-2 restoring divider, one quotient bit per iSTEP, DIVIDEND_WIDTH steps.
// oQUOTIENT_NEXT exposes the value the quotient takes after the current step.
module seq_restoring_div
  import centroid_divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DIV_STEPS,
  parameter int DIVISOR_WIDTH  = SUM_S_W
) (
  input  logic                      CCLK,
  input  logic                      RST,
  input  logic                      iLOAD,
  input  logic                      iSTEP,
  input  logic [DIVIDEND_WIDTH-1:0] iDIVIDEND,
  input  logic [DIVISOR_WIDTH-1:0]  iDIVISOR,
  output logic [DIVIDEND_WIDTH-1:0] oQUOTIENT,
  output logic [DIVIDEND_WIDTH-1:0] oQUOTIENT_NEXT,
  output logic [DIVISOR_WIDTH:0]    oREMAINDER,
  output logic                      oLAST,
  output logic                      oDONE
);

  localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

  logic [DIVISOR_WIDTH:0]    rem;
  logic [DIVISOR_WIDTH:0]    rem_next;
  logic [DIVISOR_WIDTH:0]    shifted;
  logic [DIVIDEND_WIDTH-1:0] quo;
  logic [DIVIDEND_WIDTH-1:0] quo_next;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic [CW-1:0]             count;
  logic                      fits;

  // The remainder stays below the divisor, so the shifted partial remainder
  // always fits in DIVISOR_WIDTH+1 bits.
  always_comb begin
    shifted  = {rem[DIVISOR_WIDTH-1:0], quo[DIVIDEND_WIDTH-1]};
    fits     = (shifted >= {1'b0, divisor});
    rem_next = fits ? (shifted - {1'b0, divisor}) : shifted;
    quo_next = {quo[DIVIDEND_WIDTH-2:0], fits};
  end

  always_ff @(posedge CCLK) begin
    if (RST) begin
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      count   <= '0;
    end else if (iLOAD) begin
      rem     <= '0;
      quo     <= iDIVIDEND;
      divisor <= iDIVISOR;
      count   <= '0;
    end else if (iSTEP && !oDONE) begin
      rem     <= rem_next;
      quo     <= quo_next;
      count   <= count + 1'b1;
    end
  end

  assign oQUOTIENT      = quo;
  assign oQUOTIENT_NEXT = quo_next;
  assign oREMAINDER     = rem;
  assign oDONE          = (count == CW'(DIVIDEND_WIDTH));
  assign oLAST          = iSTEP && (count == CW'(DIVIDEND_WIDTH - 1));

endmodule

// File: rtl/centroid_divider.sv
// Pupil centroid: cx = sum_sx/sum_s, cy = sum_sy/sum_s as UQ fixed point,
// computed with one time-shared divider and offered over valid/ready.
module centroid_divider
  import centroid_divider_pkg::*;
#(
  parameter int SUM_S_WIDTH  = SUM_S_W,
  parameter int SUM_XY_WIDTH = SUM_XY_W,
  parameter int COORD_WIDTH  = COORD_W,
  parameter int FRAC_WIDTH   = FRAC_W
) (
  input  logic                              CCLK,
  input  logic                              RST,
  input  logic                              iSTART,
  input  logic [SUM_S_WIDTH-1:0]            iSUM_S,
  input  logic [SUM_XY_WIDTH-1:0]           iSUM_SX,
  input  logic [SUM_XY_WIDTH-1:0]           iSUM_SY,
  output logic                              oBUSY,
  output logic                              oVALID,
  input  logic                              iREADY,
  output logic [COORD_WIDTH+FRAC_WIDTH-1:0] oCX,
  output logic [COORD_WIDTH+FRAC_WIDTH-1:0] oCY,
  output logic                              oZERO,
  output logic                              oOVF
);

  localparam int N  = SUM_XY_WIDTH + FRAC_WIDTH;
  localparam int OW = COORD_WIDTH + FRAC_WIDTH;

  state_t                  state;
  logic [SUM_S_WIDTH-1:0]  sum_s;
  logic [SUM_XY_WIDTH-1:0] sum_sx;
  logic [SUM_XY_WIDTH-1:0] sum_sy;
  logic [OW-1:0]           cx_hold;
  logic                    ovf_x;

  logic                    div_load;
  logic                    div_step;
  logic [N-1:0]            div_dividend;
  logic [N-1:0]            div_quotient;
  logic [N-1:0]            div_quotient_next;
  logic [SUM_S_WIDTH:0]    unused_rem;
  logic                    unused_done;
  logic                    div_last;

  function automatic logic over_range(input logic [N-1:0] q);
    return |q[N-1:OW];
  endfunction

  function automatic logic [OW-1:0] saturate(input logic [N-1:0] q);
    return over_range(q) ? {OW{1'b1}} : q[OW-1:0];
  endfunction

  assign div_load     = (state == LOAD_X) || (state == LOAD_Y);
  assign div_step     = (state == DIV_X) || (state == DIV_Y);
  assign div_dividend = (state == LOAD_Y) ? {sum_sy, {FRAC_WIDTH{1'b0}}}
                                          : {sum_sx, {FRAC_WIDTH{1'b0}}};

  seq_restoring_div #(
    .DIVIDEND_WIDTH(N),
    .DIVISOR_WIDTH (SUM_S_WIDTH)
  ) u_div (
    .CCLK          (CCLK),
    .RST           (RST),
    .iLOAD         (div_load),
    .iSTEP         (div_step),
    .iDIVIDEND     (div_dividend),
    .iDIVISOR      (sum_s),
    .oQUOTIENT     (div_quotient),
    .oQUOTIENT_NEXT(div_quotient_next),
    .oREMAINDER    (unused_rem),
    .oLAST         (div_last),
    .oDONE         (unused_done)
  );

  // The Y result is registered on the final divide step itself so the
  // result is presented straight out of DIV_Y without an extra cycle.
  always_ff @(posedge CCLK) begin
    if (RST) begin
      state   <= IDLE;
      sum_s   <= '0;
      sum_sx  <= '0;
      sum_sy  <= '0;
      cx_hold <= '0;
      ovf_x   <= 1'b0;
      oBUSY   <= 1'b0;
      oVALID  <= 1'b0;
      oCX     <= '0;
      oCY     <= '0;
      oZERO   <= 1'b0;
      oOVF    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iSTART) begin
            sum_s  <= iSUM_S;
            sum_sx <= iSUM_SX;
            sum_sy <= iSUM_SY;
            oBUSY  <= 1'b1;
            oOVF   <= 1'b0;
            if (iSUM_S == '0) begin
              oZERO  <= 1'b1;
              oCX    <= '0;
              oCY    <= '0;
              oVALID <= 1'b1;
              state  <= OUT;
            end else begin
              oZERO  <= 1'b0;
              state  <= LOAD_X;
            end
          end
        end
        LOAD_X: state <= DIV_X;
        DIV_X: begin
          if (div_last) state <= LOAD_Y;
        end
        LOAD_Y: begin
          cx_hold <= saturate(div_quotient);
          ovf_x   <= over_range(div_quotient);
          state   <= DIV_Y;
        end
        DIV_Y: begin
          if (div_last) begin
            oCX    <= cx_hold;
            oCY    <= saturate(div_quotient_next);
            oOVF   <= ovf_x | over_range(div_quotient_next);
            oVALID <= 1'b1;
            state  <= OUT;
          end
        end
        OUT: begin
          if (iREADY) begin
            oVALID <= 1'b0;
            oBUSY  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_centroid_divider.sv
// Scoreboard bench for centroid_divider: directed sums with hand-computed
// centroids, latency, backpressure hold and mid-divide reset.
module tb_centroid_divider;

  logic        CCLK;
  logic        RST;
  logic        iSTART;
  logic [19:0] iSUM_S;
  logic [27:0] iSUM_SX;
  logic [27:0] iSUM_SY;
  logic        oBUSY;
  logic        oVALID;
  logic        iREADY;
  logic [13:0] oCX;
  logic [13:0] oCY;
  logic        oZERO;
  logic        oOVF;

  typedef struct packed {
    logic [13:0] cx;
    logic [13:0] cy;
    logic        zero;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  centroid_divider dut (
    .CCLK   (CCLK),
    .RST    (RST),
    .iSTART (iSTART),
    .iSUM_S (iSUM_S),
    .iSUM_SX(iSUM_SX),
    .iSUM_SY(iSUM_SY),
    .oBUSY  (oBUSY),
    .oVALID (oVALID),
    .iREADY (iREADY),
    .oCX    (oCX),
    .oCY    (oCY),
    .oZERO  (oZERO),
    .oOVF   (oOVF)
  );

  initial CCLK = 1'b0;
  always #5 CCLK = ~CCLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every completed handshake is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge CCLK);
      if (oVALID === 1'b1 && iREADY === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_result: got cx=%0d cy=%0d, expected no result", oCX, oCY);
        end else begin
          e = sb.pop_front();
          checkOutput("cx",   32'(oCX),   32'(e.cx));
          checkOutput("cy",   32'(oCY),   32'(e.cy));
          checkOutput("zero", 32'(oZERO), 32'(e.zero));
          checkOutput("ovf",  32'(oOVF),  32'(e.ovf));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [19:0] s, input logic [27:0] sx,
                               input logic [27:0] sy, input logic [13:0] ecx,
                               input logic [13:0] ecy, input logic ez,
                               input logic eo, input int elat,
                               input string name);
    int lat;
    sb.push_back('{cx: ecx, cy: ecy, zero: ez, ovf: eo});
    iSUM_S  = s;
    iSUM_SX = sx;
    iSUM_SY = sy;
    iSTART  = 1'b1;
    @(posedge CCLK); #1;
    iSTART  = 1'b0;
    iSUM_S  = ~s;
    iSUM_SX = ~sx;
    iSUM_SY = ~sy;
    lat = 0;
    while (oVALID !== 1'b1 && lat < 200) begin
      @(posedge CCLK); #1;
      lat++;
    end
    checkOutput({name, "_latency"}, 32'(lat), 32'(elat));
    checkOutput({name, "_busy"}, 32'(oBUSY), 32'd1);
    if (iREADY) begin
      @(posedge CCLK); #1;
      checkOutput({name, "_valid_drop"}, 32'(oVALID), 32'd0);
      checkOutput({name, "_busy_drop"}, 32'(oBUSY), 32'd0);
    end
  endtask

  initial begin
    iSTART  = 1'b0;
    iSUM_S  = '0;
    iSUM_SX = '0;
    iSUM_SY = '0;
    iREADY  = 1'b1;
    RST     = 1'b1;
    repeat (3) @(posedge CCLK);
    #1;
    checkOutput("reset_busy",  32'(oBUSY),  32'd0);
    checkOutput("reset_valid", 32'(oVALID), 32'd0);
    checkOutput("reset_cx",    32'(oCX),    32'd0);
    checkOutput("reset_cy",    32'(oCY),    32'd0);
    checkOutput("reset_flags", 32'({oZERO, oOVF}), 32'd0);
    RST = 1'b0;
    @(posedge CCLK); #1;

    applyStimulus(20'd100, 28'd32000, 28'd24000, 14'd5120, 14'd3840, 1'b0, 1'b0, 66, "basic");
    applyStimulus(20'd3,   28'd10,    28'd2,     14'd53,   14'd10,   1'b0, 1'b0, 66, "fraction");
    applyStimulus(20'd0,   28'd12345, 28'd999,   14'd0,    14'd0,    1'b1, 1'b0, 0,  "zero");
    applyStimulus(20'd1,   28'd2000,  28'd5,     14'd16383, 14'd80,  1'b0, 1'b1, 66, "overflow");
    applyStimulus(20'hFFFFF, 28'hFFFFFFF, 28'd0, 14'd4096, 14'd0,    1'b0, 1'b0, 66, "max");

    // Backpressure: result must hold, and a start during the hold is ignored.
    iREADY = 1'b0;
    applyStimulus(20'd7, 28'd1000, 28'd999, 14'd2285, 14'd2283, 1'b0, 1'b0, 66, "hold");
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        iSUM_S  = 20'd1;
        iSUM_SX = 28'd1;
        iSUM_SY = 28'd1;
        iSTART  = 1'b1;
      end
      @(posedge CCLK); #1;
      iSTART = 1'b0;
      checkOutput("hold_valid", 32'(oVALID), 32'd1);
      checkOutput("hold_cx",    32'(oCX),    32'd2285);
      checkOutput("hold_cy",    32'(oCY),    32'd2283);
    end
    iREADY = 1'b1;
    @(posedge CCLK); #1;
    checkOutput("hold_release_valid", 32'(oVALID), 32'd0);
    checkOutput("hold_release_busy",  32'(oBUSY),  32'd0);
    applyStimulus(20'd100, 28'd32000, 28'd24000, 14'd5120, 14'd3840, 1'b0, 1'b0, 66, "after_hold");

    // Leave oOVF set, then abort a divide with reset 30 cycles into DIV_X.
    applyStimulus(20'd1, 28'd2000, 28'd5, 14'd16383, 14'd80, 1'b0, 1'b1, 66, "overflow2");
    iSUM_S  = 20'd100;
    iSUM_SX = 28'd32000;
    iSUM_SY = 28'd24000;
    iSTART  = 1'b1;
    @(posedge CCLK); #1;
    iSTART = 1'b0;
    @(posedge CCLK); #1;
    repeat (30) @(posedge CCLK);
    #1;
    RST = 1'b1;
    @(posedge CCLK); #1;
    checkOutput("abort_busy",  32'(oBUSY),  32'd0);
    checkOutput("abort_valid", 32'(oVALID), 32'd0);
    checkOutput("abort_cx",    32'(oCX),    32'd0);
    checkOutput("abort_cy",    32'(oCY),    32'd0);
    checkOutput("abort_zero",  32'(oZERO),  32'd0);
    checkOutput("abort_ovf",   32'(oOVF),   32'd0);
    RST = 1'b0;
    repeat (40) begin
      @(posedge CCLK); #1;
      checkOutput("abort_no_valid", 32'(oVALID), 32'd0);
    end
    applyStimulus(20'd3, 28'd10, 28'd2, 14'd53, 14'd10, 1'b0, 1'b0, 66, "after_abort");

    repeat (3) @(posedge CCLK);
    #1;
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/centroid_divider.md
Name: centroid_divider

Overview:
- Downstream stage of the Y/X gravity accumulator.
- Takes the frame totals: pixel count sum_s, X-moment sum_sx and Y-moment sum_sy.
- Computes the pupil centroid (cx = sum_sx/sum_s, cy = sum_sy/sum_s) as unsigned fixed-point, using one shared sequential radix-2 restoring divider.
- Hands the result to the UART report stage over a valid/ready handshake. Replaces the vendor divider cores with portable RTL.

Parameters:
SUM_S_WIDTH, 20, width of pixel-count input (divisor)
SUM_XY_WIDTH, 28, width of moment inputs (dividends)
COORD_WIDTH, 10, integer bits of each output coordinate (covers 0..1023)
FRAC_WIDTH, 4, fractional bits of each output coordinate

Ports:
CCLK  in  1  clock
RST  in  1  synchronous active-high reset
iSTART  in  1  one-cycle pulse: sums valid, begin computation
iSUM_S  in  SUM_S_WIDTH  pixel count above threshold
iSUM_SX  in  SUM_XY_WIDTH  sum of x over counted pixels
iSUM_SY  in  SUM_XY_WIDTH  sum of y over counted pixels
oBUSY  out  1  high from accepted iSTART until output handshake completes
oVALID  out  1  result valid
iREADY  in  1  consumer accepts result
oCX  out  COORD_WIDTH+FRAC_WIDTH  centroid x, UQ(COORD_WIDTH.FRAC_WIDTH)
oCY  out  COORD_WIDTH+FRAC_WIDTH  centroid y, same format
oZERO  out  1  sum_s was zero; oCX/oCY forced 0
oOVF  out  1  a quotient exceeded output range and was saturated

Behaviour:
- One clock (CCLK). Reset is synchronous and active-high (RST). On RST: state IDLE; all outputs 0 (oBUSY, oVALID, oCX, oCY, oZERO, oOVF). RST mid-operation aborts immediately; no partial result is ever presented.
- Let N = SUM_XY_WIDTH+FRAC_WIDTH (default 32). Each dividend is {sum, FRAC_WIDTH zeros}, so quotient = floor(sum*2^FRAC_WIDTH / sum_s), truncated and never rounded.
- iSTART is sampled only in IDLE. In IDLE the block captures all three sums into internal registers, so upstream may change them afterwards. iSTART in any other state is ignored.
- States:
  - IDLE: oBUSY=0. On iSTART: if iSUM_S==0 go to OUT with oZERO=1 and oCX=oCY=0; else go to LOAD_X.
  - LOAD_X (1 cycle): init divider with sum_sx and sum_s.
  - DIV_X (N cycles): one shift/subtract per cycle.
  - LOAD_Y (1 cycle): store the X quotient, init divider with sum_sy.
  - DIV_Y (N cycles).
  - OUT: oVALID=1. Outputs and flags are held stable until iVALID&&iREADY completes; on that cycle go to IDLE, and oVALID drops on the next edge.
- Latency, nonzero case: iSTART sampled at edge 0 → oVALID high after edge 2N+2 (66 with defaults). Zero case: oVALID high after edge 0.
- oBUSY=1 in every state except IDLE, and is also 1 in OUT.
- Saturation: if a quotient needs more than COORD_WIDTH+FRAC_WIDTH bits, that coordinate = all ones and oOVF=1. oOVF is the OR over both coordinates.
- oZERO and oOVF are cleared on the next accepted iSTART and are valid only while oVALID=1.
- Divider remainder register is SUM_S_WIDTH+1 bits. Quotient register is N bits; the upper bits are used only for overflow detection.
- iREADY may be high before oVALID. In that case the handshake completes on the first oVALID cycle: a one-cycle OUT.

Decomposition:
- Shared package: default widths, the state encoding (IDLE, LOAD_X, DIV_X, LOAD_Y, DIV_Y, OUT) and N as a derived constant.
- One sub-module: seq_restoring_div (parameterised dividend/divisor widths; iLOAD/iSTEP inputs; quotient/remainder outputs; oDONE after N steps). It is instantiated once and time-shared between X and Y.

Test Plan:
- Basic: sum_s=100, sum_sx=32000, sum_sy=24000, iREADY=1 → after 66 cycles oCX=5120 (320.0), oCY=3840 (240.0); oZERO=0, oOVF=0; one-cycle oVALID.
- Fraction: sum_s=3, sum_sx=10, sum_sy=2 → oCX=53 (3.3125), oCY=10 (0.625).
- Zero: sum_s=0, any moments → oVALID after 1 cycle, oCX=oCY=0, oZERO=1.
- Overflow: sum_s=1, sum_sx=2000, sum_sy=5 → oCX=16383, oOVF=1, oCY=80.
- Backpressure: iREADY low for 20 cycles after oVALID → outputs stable. A second iSTART during the hold is ignored. After iREADY pulse → IDLE, and the next iSTART gives latency 66 again.
- Reset mid-op: RST at cycle 30 of DIV_X → next edge all outputs 0, IDLE. A fresh iSTART then gives the correct result with no stale flags.
